lpddr_burst_writer: RTL and testbench
=====================================

Name: lpddr_burst_writer

Overview:
- Initiator-side sequencer for the write port of the LPDDR MCB (port 0).
- Accepts a valid/ready stream of 32-bit words and packs them into bursts in the MCB write-data FIFO.
- For each burst, issues one write command with the correct burst length and byte address, then advances the address pointer with wrap-around.
- Replaces host-driven level toggling of cmd_en/wr_en with a self-timed engine.

Parameters:
- BURST_LEN, 32, words per full burst (1..64); cmd_bl = words-1
- ADDR_W, 30, MCB byte-address width
- ADDR_LIMIT, 30'h0400_0000, exclusive upper byte address; the pointer wraps to base at or beyond this
- CNT_W, 16, width of the burst counter

Ports:
- clkA_addr  in  1  block clock, same domain as the MCB p0 cmd/wr clocks
- addr_rstA_wr  in  1  asynchronous active-high reset
- calib_done  in  1  MCB calibration complete
- base_addr  in  ADDR_W  start byte address; bits[1:0] ignored (forced 0)
- base_load  in  1  load base_addr into the address pointer
- flush  in  1  pulse: commit a partial burst now
- src_valid  in  1  input word valid
- src_data  in  32  input word
- src_ready  out  1  word accepted when src_valid&src_ready
- p0_wr_en  out  1  MCB write-FIFO push
- p0_wr_data  out  32  MCB write data
- p0_wr_mask  out  4  always 4'b0000
- p0_wr_full  in  1  MCB write FIFO full
- p0_wr_empty  in  1  MCB write FIFO empty
- p0_cmd_en  out  1  one-cycle command strobe
- p0_cmd_instr  out  3  always 3'b000 (write)
- p0_cmd_bl  out  6  burst length minus one
- p0_cmd_byte_addr  out  ADDR_W  command byte address
- p0_cmd_full  in  1  MCB command FIFO full
- busy  out  1  high in any state other than IDLE and empty FILL
- bursts_done  out  CNT_W  count of commands issued, wraps at 2^CNT_W

Behaviour:
- Reset (addr_rstA_wr high, async):
  - state=IDLE; word cnt=0; addr ptr=0.
  - All outputs 0: src_ready, p0_wr_en, p0_cmd_en, p0_cmd_bl, p0_cmd_byte_addr, busy, bursts_done.
  - Reset asserted mid-burst abandons the burst; no command is issued.
- IDLE:
  - Waits for calib_done=1, then moves to FILL.
  - base_load is honoured in IDLE.
- FILL:
  - src_ready = !p0_wr_full && cnt<BURST_LEN.
  - Pass-through is combinational: p0_wr_en = src_valid&src_ready, p0_wr_data = src_data, zero latency.
  - cnt increments on each accept.
  - Exit to CMD when:
    - cnt reaches BURST_LEN (same cycle as the last accept, registered next cycle), or
    - flush=1 with cnt>0. Flush with cnt=0 is ignored.
  - If flush arrives in the same cycle as an accept, that word is included in the burst.
  - base_load is honoured only when cnt=0; otherwise it is ignored.
- CMD:
  - src_ready=0.
  - When !p0_cmd_full: p0_cmd_en=1 for exactly one cycle, p0_cmd_bl=cnt-1, p0_cmd_byte_addr=ptr.
  - Same edge: ptr += cnt*4; bursts_done++; cnt=0; go to DRAIN.
  - Wrap: if the new ptr >= ADDR_LIMIT, ptr = latched base (last base_load value, 0 after reset).
  - While p0_cmd_full=1, the block holds in CMD with p0_cmd_en=0.
- DRAIN:
  - src_ready=0.
  - Waits for p0_wr_empty=1, then returns to FILL. This guarantees FIFO data never mixes across bursts.
- Calibration loss: calib_done falling in any state returns the block to IDLE after the current CMD completes. A burst already in FILL is discarded (cnt=0).
- p0_cmd_bl and p0_cmd_byte_addr hold their last values between commands.
- busy = (state!=IDLE) && !(state==FILL && cnt==0).

Test Plan:
- Reset, calib_done=1, base_load 0x100, stream 32 words 0..31 back-to-back:
  - 32 wr_en pulses, data matches.
  - One p0_cmd_en with bl=31, addr=0x100.
  - Next ptr=0x180.
  - bursts_done=1.
- 5 words then flush:
  - cmd bl=4, addr=ptr.
  - ptr advances by 20.
  - Flush with cnt=0 produces no cmd.
- Hold p0_wr_full high for 10 cycles mid-burst: src_ready low, no wr_en, no word lost; burst completes with 32 words.
- p0_cmd_full high 7 cycles in CMD: p0_cmd_en fires exactly once, on the first cycle after full drops.
- ADDR_LIMIT=0x200, base 0x100: bursts go to 0x100, 0x180, then 0x100 (wrap).
- Assert addr_rstA_wr after 12 words: all outputs 0 immediately, no command issued; after release, the block waits for calib_done again.

Source files
------------

// File: rtl/lpddr_burst_writer.sv
// Self-timed write sequencer for LPDDR MCB port 0: packs a 32-bit word stream into
// write-FIFO bursts and issues one write command per burst with wrapping byte address.
module lpddr_burst_writer #(
    parameter int unsigned       BURST_LEN  = 32,
    parameter int unsigned       ADDR_W     = 30,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0400_0000),
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clkA_addr,
    input  logic              addr_rstA_wr,
    input  logic              calib_done,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              base_load,
    input  logic              flush,
    input  logic              src_valid,
    input  logic [31:0]       src_data,
    output logic              src_ready,
    output logic              p0_wr_en,
    output logic [31:0]       p0_wr_data,
    output logic [3:0]        p0_wr_mask,
    input  logic              p0_wr_full,
    input  logic              p0_wr_empty,
    output logic              p0_cmd_en,
    output logic [2:0]        p0_cmd_instr,
    output logic [5:0]        p0_cmd_bl,
    output logic [ADDR_W-1:0] p0_cmd_byte_addr,
    input  logic              p0_cmd_full,
    output logic              busy,
    output logic [CNT_W-1:0]  bursts_done
);

    localparam int unsigned CntBits = $clog2(BURST_LEN + 1);
    localparam logic [CntBits-1:0] BurstMax = CntBits'(BURST_LEN);

    typedef enum logic [1:0] {StIdle, StFill, StCmd, StDrain} state_e;

    state_e              state_q, state_d;
    logic [CntBits-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [5:0]          bl_q, bl_d;
    logic [CNT_W-1:0]    done_q, done_d;

    logic                accept;
    logic                cmd_fire;
    logic                load_ok;
    logic [ADDR_W:0]     ptr_next;
    logic [ADDR_W-1:0]   base_aligned;
    logic                unused_base_lsbs;

    assign base_aligned     = {base_addr[ADDR_W-1:2], 2'b00};
    assign unused_base_lsbs = ^base_addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        addr_d  = addr_q;
        bl_d    = bl_q;
        done_d  = done_q;

        // Gating on calib_done keeps words out of the FIFO for a burst about to be dropped.
        src_ready = (state_q == StFill) && calib_done && !p0_wr_full && (cnt_q < BurstMax);
        accept    = src_valid && src_ready;
        cmd_fire  = (state_q == StCmd) && !p0_cmd_full;
        ptr_next  = {1'b0, ptr_q} + ((ADDR_W + 1)'(cnt_q) << 2);
        load_ok   = base_load && ((state_q == StIdle) ||
                                  ((state_q == StFill) && (cnt_q == '0)));

        if (load_ok) begin
            base_d = base_aligned;
            ptr_d  = base_aligned;
        end

        unique case (state_q)
            StIdle: begin
                if (calib_done) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (!calib_done) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    if (accept) begin
                        cnt_d = cnt_q + CntBits'(1);
                    end
                    // Latch the command fields now so they are stable throughout CMD.
                    if ((cnt_d == BurstMax) || (flush && (cnt_d != '0))) begin
                        state_d = StCmd;
                        bl_d    = 6'(cnt_d - CntBits'(1));
                        addr_d  = ptr_d;
                    end
                end
            end
            StCmd: begin
                if (cmd_fire) begin
                    cnt_d   = '0;
                    done_d  = done_q + CNT_W'(1);
                    ptr_d   = (ptr_next >= {1'b0, ADDR_LIMIT}) ? base_q : ptr_next[ADDR_W-1:0];
                    state_d = calib_done ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (!calib_done) begin
                    state_d = StIdle;
                end else if (p0_wr_empty) begin
                    state_d = StFill;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clkA_addr or posedge addr_rstA_wr) begin
        if (addr_rstA_wr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            bl_q    <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            bl_q    <= bl_d;
            done_q  <= done_d;
        end
    end

    assign p0_wr_en         = accept;
    assign p0_wr_data       = src_data;
    assign p0_wr_mask       = 4'b0000;
    assign p0_cmd_en        = cmd_fire;
    assign p0_cmd_instr     = 3'b000;
    assign p0_cmd_bl        = bl_q;
    assign p0_cmd_byte_addr = addr_q;
    assign busy             = (state_q != StIdle) && !((state_q == StFill) && (cnt_q == '0));
    assign bursts_done      = done_q;

endmodule

// File: tb/tb_lpddr_burst_writer.sv
// Directed + randomized bench for lpddr_burst_writer; a transaction-level model predicts
// the write-data stream and the command sequence (length, address, wrap).
module tb_lpddr_burst_writer;

    localparam int unsigned   BL    = 32;
    localparam int unsigned   AW    = 30;
    localparam int unsigned   CW    = 16;
    localparam logic [AW-1:0] Limit = 30'h200;

    logic          clk = 1'b0;
    logic          rst;
    logic          calib_done;
    logic [AW-1:0] base_addr;
    logic          base_load;
    logic          flush;
    logic          src_valid;
    logic [31:0]   src_data;
    logic          src_ready;
    logic          p0_wr_en;
    logic [31:0]   p0_wr_data;
    logic [3:0]    p0_wr_mask;
    logic          p0_wr_full;
    logic          p0_wr_empty;
    logic          p0_cmd_en;
    logic [2:0]    p0_cmd_instr;
    logic [5:0]    p0_cmd_bl;
    logic [AW-1:0] p0_cmd_byte_addr;
    logic          p0_cmd_full;
    logic          busy;
    logic [CW-1:0] bursts_done;

    lpddr_burst_writer #(
        .BURST_LEN  (BL),
        .ADDR_W     (AW),
        .ADDR_LIMIT (Limit),
        .CNT_W      (CW)
    ) dut (
        .clkA_addr        (clk),
        .addr_rstA_wr     (rst),
        .calib_done       (calib_done),
        .base_addr        (base_addr),
        .base_load        (base_load),
        .flush            (flush),
        .src_valid        (src_valid),
        .src_data         (src_data),
        .src_ready        (src_ready),
        .p0_wr_en         (p0_wr_en),
        .p0_wr_data       (p0_wr_data),
        .p0_wr_mask       (p0_wr_mask),
        .p0_wr_full       (p0_wr_full),
        .p0_wr_empty      (p0_wr_empty),
        .p0_cmd_en        (p0_cmd_en),
        .p0_cmd_instr     (p0_cmd_instr),
        .p0_cmd_bl        (p0_cmd_bl),
        .p0_cmd_byte_addr (p0_cmd_byte_addr),
        .p0_cmd_full      (p0_cmd_full),
        .busy             (busy),
        .bursts_done      (bursts_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int const_bad = 0;

    logic [31:0] got_wr[$];
    logic [31:0] exp_wr[$];
    logic [35:0] got_cmd[$];
    logic [35:0] exp_cmd[$];
    logic [35:0] last_cmd;

    // Transaction-level model state
    int          mcnt;
    logic [AW-1:0] mptr;
    logic [AW-1:0] mbase;
    int          mbursts;

    always @(negedge clk) begin
        if (!rst) begin
            if (p0_wr_en) got_wr.push_back(p0_wr_data);
            if (p0_cmd_en) got_cmd.push_back({p0_cmd_bl, p0_cmd_byte_addr});
            if (p0_wr_mask !== 4'h0 || p0_cmd_instr !== 3'h0) const_bad++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_commit();
        exp_cmd.push_back({6'(mcnt - 1), mptr});
        mptr = mptr + AW'(mcnt * 4);
        if (mptr >= Limit) mptr = mbase;
        mbursts++;
        mcnt = 0;
    endtask

    task automatic model_reset();
        mcnt = 0; mptr = '0; mbase = '0; mbursts = 0;
        got_wr.delete(); exp_wr.delete(); got_cmd.delete(); exp_cmd.delete();
    endtask

    task automatic push_word(input logic [31:0] d, input bit gaps, input bit fl);
        bit ok = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        src_valid = 1'b1; src_data = d; flush = fl;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (src_ready) begin ok = 1; break; end
        end
        chk("accept", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk); #1;
        end
        src_valid = 1'b0; flush = 1'b0;
        if (ok) begin
            exp_wr.push_back(d);
            mcnt++;
            if (mcnt == BL || fl) model_commit();
        end
    endtask

    task automatic push_n(input int n, input bit gaps);
        for (int i = 0; i < n; i++) push_word($urandom, gaps, 1'b0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (mcnt > 0) model_commit();
    endtask

    task automatic load_base(input logic [AW-1:0] a);
        base_addr = a; base_load = 1'b1;
        @(posedge clk); #1;
        base_load = 1'b0;
        mbase = {a[AW-1:2], 2'b00};
        mptr  = mbase;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk({tag, "_idle"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string tag);
        wait_idle(tag);
        chk({tag, "_wr_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++)
            if (i < got_wr.size())
                chk($sformatf("%s_wr%0d", tag, i), 64'(got_wr[i]), 64'(exp_wr[i]));
        chk({tag, "_cmd_count"}, 64'(got_cmd.size()), 64'(exp_cmd.size()));
        for (int i = 0; i < exp_cmd.size(); i++)
            if (i < got_cmd.size())
                chk($sformatf("%s_cmd%0d", tag, i), 64'(got_cmd[i]), 64'(exp_cmd[i]));
        if (exp_cmd.size() > 0) last_cmd = exp_cmd[exp_cmd.size() - 1];
        chk({tag, "_bursts_done"}, 64'(bursts_done), 64'(mbursts % (1 << CW)));
        chk({tag, "_cmd_hold"}, 64'({p0_cmd_bl, p0_cmd_byte_addr}), 64'(last_cmd));
        got_wr.delete(); exp_wr.delete(); got_cmd.delete(); exp_cmd.delete();
    endtask

    initial begin
        int bad;
        logic [31:0] w;
        rst = 1'b0; calib_done = 1'b0; base_addr = '0; base_load = 1'b0; flush = 1'b0;
        src_valid = 1'b0; src_data = '0; p0_wr_full = 1'b0; p0_wr_empty = 1'b1;
        p0_cmd_full = 1'b0; last_cmd = '0;
        model_reset();

        #3 rst = 1'b1;
        #2;
        chk("reset_outputs", 64'({src_ready, p0_wr_en, p0_cmd_en, p0_cmd_bl, p0_cmd_byte_addr,
                                  busy, bursts_done}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // No calibration yet: must stay idle.
        src_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_ready", 64'(src_ready), 64'd0);
        @(posedge clk); #1;
        src_valid = 1'b0; calib_done = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("fill_empty_not_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Full burst of 0..31 at base 0x100 (low address bits dropped).
        load_base(30'h103);
        for (int i = 0; i < 32; i++) push_word(32'(i), 1'b0, 1'b0);
        check_stream("full_burst");

        // Partial burst via flush, then a flush with nothing pending.
        push_n(5, 1'b0);
        do_flush();
        check_stream("flush5");
        do_flush();
        repeat (4) @(negedge clk);
        check_stream("flush_empty");

        // Flush arriving together with the last word includes it.
        push_n(2, 1'b0);
        push_word($urandom, 1'b0, 1'b1);
        check_stream("flush_same_cycle");

        // Write FIFO full mid-burst.
        push_n(10, 1'b0);
        w = $urandom;
        src_valid = 1'b1; src_data = w; p0_wr_full = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (src_ready || p0_wr_en) bad++;
        end
        chk("wr_full_stall", 64'(bad), 64'd0);
        @(posedge clk); #1;
        p0_wr_full = 1'b0;
        push_word(w, 1'b0, 1'b0);
        push_n(21, 1'b0);
        check_stream("wr_full");

        // Command FIFO full for 7 cycles while in CMD.
        p0_cmd_full = 1'b1;
        push_n(32, 1'b0);
        bad = 0;
        repeat (7) begin
            @(negedge clk);
            if (p0_cmd_en || src_ready) bad++;
        end
        chk("cmd_full_hold", 64'(bad), 64'd0);
        @(posedge clk); #1;
        p0_cmd_full = 1'b0;
        @(negedge clk);
        chk("cmd_en_after_full", 64'(p0_cmd_en), 64'd1);
        @(negedge clk);
        chk("cmd_en_single", 64'(p0_cmd_en), 64'd0);
        check_stream("cmd_full");

        // Drain waits for the write FIFO to empty.
        p0_wr_empty = 1'b0;
        push_n(2, 1'b0);
        do_flush();
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (!busy || src_ready) bad++;
        end
        chk("drain_hold", 64'(bad), 64'd0);
        @(posedge clk); #1;
        p0_wr_empty = 1'b1;
        check_stream("drain");

        // Address wrap: 0x100, 0x180, back to 0x100.
        load_base(30'h100);
        push_n(96, 1'b1);
        check_stream("wrap");

        // Randomized bursts with gaps.
        for (int k = 0; k < 6; k++) begin
            push_n($urandom_range(1, 40), 1'b1);
            do_flush();
            check_stream($sformatf("rand%0d", k));
        end

        // Reset mid-burst abandons it.
        push_n(12, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 64'({src_ready, p0_wr_en, p0_cmd_en, p0_cmd_bl, p0_cmd_byte_addr,
                                    busy, bursts_done}), 64'd0);
        chk("rst_mid_no_cmd", 64'(got_cmd.size()), 64'd0);
        model_reset();
        last_cmd = '0;
        calib_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        src_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (src_ready || busy) bad++;
        end
        chk("post_rst_wait_calib", 64'(bad), 64'd0);
        @(posedge clk); #1;
        src_valid = 1'b0; calib_done = 1'b1;
        @(posedge clk); #1;
        push_n(3, 1'b0);
        do_flush();
        check_stream("post_rst");

        chk("const_outputs", 64'(const_bad), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
